// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding and register-file constants.
package cpu_pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        LU_HOLD = 1'b1
    } hazard_state_t;

    localparam int REG_AW_DEF = 5;
    localparam logic [REG_AW_DEF-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with enable; stops at all-ones until reset.
module hazard_perf_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall / branch-jump squash controller for the 5-stage pipeline.
// Optional saturating perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
`ifdef HAZARD_PERF_CNT_EN
    parameter int CNT_W      = 32,
`endif
    parameter int LU_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_jump,
    input  logic              ex_MemRead,
    input  logic [REG_AW-1:0] ex_write_addr,
    input  logic              ex_branch_taken,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_flush
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
`endif
);

    hazard_state_t r_state, w_next_state;
    logic [3:0]    r_bub_cnt, w_next_cnt;
    logic          w_lu_hit;

    assign w_lu_hit = ex_MemRead && (ex_write_addr != REG_AW'(REG_ZERO)) &&
                      ((id_uses_rs && (id_rs_addr == ex_write_addr)) ||
                       (id_uses_rt && (id_rt_addr == ex_write_addr)));

    // lu_hit is ignored in LU_HOLD: the load has already left EX
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        w_next_state = r_state;
        w_next_cnt   = r_bub_cnt;
        if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            w_next_state = RUN;
            w_next_cnt   = '0;
        end else if (r_state == LU_HOLD) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            w_next_cnt  = r_bub_cnt - 4'd1;
            if (r_bub_cnt == 4'd1) begin
                w_next_state = RUN;
            end
        end else if (w_lu_hit) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            if (LU_BUBBLES > 1) begin
                w_next_state = LU_HOLD;
                w_next_cnt   = 4'(LU_BUBBLES - 1);
            end
        end else if (id_jump) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= RUN;
            r_bub_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_bub_cnt <= w_next_cnt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.W(CNT_W)) u_stall_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (pc_stall),
        .o_count (stall_cycles)
    );

    hazard_perf_counter #(.W(CNT_W)) u_flush_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    (if_id_flush),
        .o_count (flush_events)
    );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: LU_BUBBLES=1 and 3 instances, plus a CNT_W=4 perf-counter instance under HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

    typedef struct {
        int         d;
        int         kind;
        logic [3:0] exp;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn [3];
    logic [4:0] rs   [3];
    logic [4:0] rt   [3];
    logic [4:0] wa   [3];
    logic       urs  [3];
    logic       urt  [3];
    logic       jmp  [3];
    logic       mr   [3];
    logic       br   [3];
    logic       ps   [3];
    logic       is   [3];
    logic       ifl  [3];
    logic       ief  [3];
    logic [3:0] sc2;
    logic [3:0] fe2;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;
    bit   done   = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(1)) u_dut1 (
        .clk(clk), .reset(rstn[0]), .id_rs_addr(rs[0]), .id_rt_addr(rt[0]),
        .id_uses_rs(urs[0]), .id_uses_rt(urt[0]), .id_jump(jmp[0]),
        .ex_MemRead(mr[0]), .ex_write_addr(wa[0]), .ex_branch_taken(br[0]),
        .pc_stall(ps[0]), .if_id_stall(is[0]), .if_id_flush(ifl[0]), .id_ex_flush(ief[0])
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cycles(), .flush_events()
`endif
    );

    hazard_ctrl #(.REG_AW(5), .LU_BUBBLES(3)) u_dut3 (
        .clk(clk), .reset(rstn[1]), .id_rs_addr(rs[1]), .id_rt_addr(rt[1]),
        .id_uses_rs(urs[1]), .id_uses_rt(urt[1]), .id_jump(jmp[1]),
        .ex_MemRead(mr[1]), .ex_write_addr(wa[1]), .ex_branch_taken(br[1]),
        .pc_stall(ps[1]), .if_id_stall(is[1]), .if_id_flush(ifl[1]), .id_ex_flush(ief[1])
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cycles(), .flush_events()
`endif
    );

`ifdef HAZARD_PERF_CNT_EN
    hazard_ctrl #(.REG_AW(5), .CNT_W(4), .LU_BUBBLES(1)) u_dutp (
        .clk(clk), .reset(rstn[2]), .id_rs_addr(rs[2]), .id_rt_addr(rt[2]),
        .id_uses_rs(urs[2]), .id_uses_rt(urt[2]), .id_jump(jmp[2]),
        .ex_MemRead(mr[2]), .ex_write_addr(wa[2]), .ex_branch_taken(br[2]),
        .pc_stall(ps[2]), .if_id_stall(is[2]), .if_id_flush(ifl[2]), .id_ex_flush(ief[2]),
        .stall_cycles(sc2), .flush_events(fe2)
    );
`else
    assign ps[2]  = 1'b0;
    assign is[2]  = 1'b0;
    assign ifl[2] = 1'b0;
    assign ief[2] = 1'b0;
    assign sc2    = '0;
    assign fe2    = '0;
`endif

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b1; rs[i] = '0; rt[i] = '0; wa[i] = '0;
            urs[i] = 1'b0; urt[i] = 1'b0; jmp[i] = 1'b0; mr[i] = 1'b0; br[i] = 1'b0;
        end
    endtask

    // One cycle of stimulus on DUT d; e = {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
    task automatic vec(input int d, input logic r, input logic [4:0] a_rs, input logic [4:0] a_rt,
                       input logic a_urs, input logic a_urt, input logic a_jmp, input logic a_mr,
                       input logic [4:0] a_wa, input logic a_br, input logic [3:0] e, input string n);
        exp_t x;
        idle_all();
        rstn[d] = r; rs[d] = a_rs; rt[d] = a_rt; urs[d] = a_urs; urt[d] = a_urt;
        jmp[d] = a_jmp; mr[d] = a_mr; wa[d] = a_wa; br[d] = a_br;
        x.d = d; x.kind = 0; x.exp = e; x.name = n;
        q.push_back(x);
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input int kind, input logic [3:0] e, input string n);
        exp_t x;
        x.d = 2; x.kind = kind; x.exp = e; x.name = n;
        q.push_back(x);
    endtask

    // Monitor: compares every pending expectation at the falling edge
    always @(negedge clk) begin
        exp_t       x;
        logic [3:0] act;
        while (q.size() > 0) begin
            x = q.pop_front();
            case (x.kind)
                0:       act = {ps[x.d], is[x.d], ifl[x.d], ief[x.d]};
                1:       act = sc2;
                default: act = fe2;
            endcase
            n_run++;
            if (act !== x.exp) begin
                n_fail++;
                $display("FAIL %s dut%0d: got %b expected %b", x.name, x.d, act, x.exp);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        idle_all();
        for (int i = 0; i < 3; i++) rstn[i] = 1'b0;
        @(posedge clk); #1;

        // LU_BUBBLES = 1, $t0 = r8
        vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "reset_state");
        vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "idle_after_reset");
        vec(0, 1, 8, 0, 1, 0, 0, 1, 8, 0, 4'b1101, "lu1_rs_stall");
        vec(0, 1, 8, 0, 1, 0, 0, 0, 0, 0, 4'b0000, "lu1_release");
        vec(0, 1, 0, 8, 0, 1, 0, 1, 8, 0, 4'b1101, "lu1_rt_stall");
        vec(0, 1, 0, 8, 0, 0, 0, 1, 8, 0, 4'b0000, "rt_not_used");
        vec(0, 1, 9, 0, 1, 0, 0, 1, 8, 0, 4'b0000, "addr_mismatch");
        vec(0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 4'b0000, "load_r0_no_stall");
        vec(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010, "jump_flush");
        vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011, "branch_flush");
        vec(0, 1, 8, 0, 1, 0, 1, 1, 8, 0, 4'b1101, "jump_lu_stall_first");
        vec(0, 1, 8, 0, 1, 0, 1, 0, 0, 0, 4'b0010, "jump_after_stall");
        vec(0, 1, 8, 0, 1, 0, 1, 1, 8, 1, 4'b0011, "branch_beats_lu");

        // LU_BUBBLES = 3
        vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "lu3_idle");
        vec(1, 1, 8, 0, 1, 0, 0, 1, 8, 0, 4'b1101, "lu3_stall_c0");
        vec(1, 1, 8, 0, 1, 0, 0, 1, 8, 0, 4'b1101, "lu3_stall_c1_hit_ignored");
        vec(1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 4'b1101, "lu3_stall_c2");
        vec(1, 1, 8, 0, 1, 0, 0, 0, 0, 0, 4'b0000, "lu3_release");
        vec(1, 1, 8, 0, 1, 0, 0, 1, 8, 0, 4'b1101, "br_stall_c0");
        vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0011, "br_in_stall_c1");
        vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "br_back_to_run");
        vec(1, 1, 8, 0, 1, 0, 1, 1, 8, 0, 4'b1101, "lu3_jump_c0");
        vec(1, 1, 8, 0, 1, 0, 1, 0, 0, 0, 4'b1101, "lu3_jump_c1");
        vec(1, 1, 8, 0, 1, 0, 1, 0, 0, 0, 4'b1101, "lu3_jump_c2");
        vec(1, 1, 8, 0, 1, 0, 1, 0, 0, 0, 4'b0010, "lu3_jump_c3");
        vec(1, 1, 8, 0, 1, 0, 0, 1, 8, 0, 4'b1101, "rst_hold_c0");
        vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1101, "rst_during_hold");
        vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "rst_abandons_stall");

`ifdef HAZARD_PERF_CNT_EN
        vec(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_idle");
        for (int k = 0; k < 20; k++) begin
            vec(2, 1, 8, 0, 1, 0, 0, 1, 8, 0, 4'b1101, "perf_stall");
        end
        chk_cnt(1, 4'hF, "stall_cycles_sat");
        chk_cnt(2, 4'h0, "flush_events_zero");
        vec(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_idle2");
        for (int k = 0; k < 3; k++) begin
            vec(2, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0010, "perf_jump");
        end
        chk_cnt(2, 4'h3, "flush_events_3");
        vec(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_reset");
        chk_cnt(1, 4'h0, "stall_cycles_cleared");
        chk_cnt(2, 4'h0, "flush_events_cleared");
        vec(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "perf_after_reset");
`endif

        @(negedge clk); #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
